// File: rtl/led_scan_reader.sv
// rtl/led_scan_reader.sv - Recovers a 4-digit hex value by sniffing a multiplexed active-low 7-segment LED scan
module led_scan_reader #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        valid,
    output logic        err
);

    typedef enum logic {COLLECT, PUBLISH} state_t;

    localparam logic [7:0] ACCEPT_AT = 8'(STABLE - 1);

    state_t      state;
    logic [10:0] s1;
    logic [10:0] s0;
    logic [7:0]  cnt;
    logic [3:0]  mask;
    logic [15:0] shadow;
    logic        frame_err;

    logic [3:0]  an_low;
    logic        one_digit;
    logic        accept;
    logic [1:0]  digit_idx;
    logic [3:0]  nibble;
    logic        bad_code;
    logic [3:0]  mask_base;
    logic [3:0]  mask_next;
    logic        ferr_base;

    // Input sampling and stability counting; reset primes the pipe with "all off"
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1  <= '1;
            s0  <= '1;
            cnt <= 8'd0;
        end else begin
            s1 <= {an, seg};
            s0 <= s1;
            if (s1 != s0)
                cnt <= 8'd0;
            else if (cnt != 8'hFF)
                cnt <= cnt + 8'd1;
        end
    end

    // Acceptance qualification: exactly one enable low while the counter hits the threshold
    always_comb begin
        an_low    = ~s1[10:7];
        one_digit = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
        accept    = one_digit && (cnt == ACCEPT_AT);
        digit_idx = 2'd0;
        case (an_low)
            4'b0010: digit_idx = 2'd1;
            4'b0100: digit_idx = 2'd2;
            4'b1000: digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase
    end

    // Segment pattern to nibble; B and D are ambiguous on 7 segments so they count as errors
    always_comb begin
        bad_code = 1'b0;
        nibble   = 4'h0;
        case (s1[6:0])
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b0110001: nibble = 4'hC;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            default: begin
                nibble   = 4'h0;
                bad_code = 1'b1;
            end
        endcase
    end

    // Frame bookkeeping: a publish cycle starts a fresh frame, so an acceptance there lands in it
    always_comb begin
        mask_base = (state == PUBLISH) ? 4'd0 : mask;
        ferr_base = (state == PUBLISH) ? 1'b0 : frame_err;
        mask_next = mask_base;
        if (accept)
            mask_next[digit_idx] = 1'b1;
    end

    // Frame FSM: collect digits into the shadow, publish for one cycle once all four are seen
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= COLLECT;
            mask      <= 4'd0;
            shadow    <= 16'h0000;
            frame_err <= 1'b0;
            value     <= 16'h0000;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == PUBLISH) begin
                value <= shadow;
                err   <= frame_err;
                valid <= 1'b1;
            end
            if (accept)
                shadow[digit_idx*4 +: 4] <= nibble;
            mask      <= mask_next;
            frame_err <= ferr_base | (accept & bad_code);
            state     <= (mask_next == 4'hF) ? PUBLISH : COLLECT;
        end
    end

endmodule

// File: tb/tb_led_scan_reader.sv
// tb/tb_led_scan_reader.sv - Directed self-checking bench for led_scan_reader
module tb_led_scan_reader;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        valid;
    logic        err;

    int n_checks;
    int n_fail;
    int valid_cnt;
    logic [15:0] last_value;
    logic        last_err;

    led_scan_reader #(.STABLE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .an    (an),
        .seg   (seg),
        .value (value),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every published frame
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt  <= valid_cnt + 1;
            last_value <= value;
            last_err   <= err;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: seg_of = 7'b0000001;
            4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;
            4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;
            4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;
            4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;
            4'hC: seg_of = 7'b0110001;
            4'hE: seg_of = 7'b0110000;
            4'hF: seg_of = 7'b0111000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int i);
        logic [3:0] a;
        a = 4'b1111;
        a[i] = 1'b0;
        return a;
    endfunction

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        an    = 4'b1111;
        seg   = 7'b1111111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        valid_cnt  = 0;
        last_value = 16'hxxxx;
        last_err   = 1'bx;
    endtask

    task automatic idle(input int n);
        hold(4'b1111, 7'b1111111, n);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (value !== 16'h0000 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: value=%h valid=%b err=%b, required 0000/0/0", value, valid, err);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int i = 0; i < 4; i++) hold(an_of(i), seg_of(4'(i + 1)), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'h4321 || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_frame: pulses=%0d value=%h err=%b, required 1/4321/0", valid_cnt, last_value, last_err);
        end
        n_checks++;
        if (value !== 16'h4321 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL value_hold: value=%h err=%b, required 4321/0", value, err);
        end
    endtask

    task automatic test_latency();
        logic [7:0] seen;
        do_reset();
        for (int i = 0; i < 3; i++) hold(an_of(i), seg_of(4'(i + 5)), 8);
        @(negedge clk);
        an  = an_of(3);
        seg = seg_of(4'h9);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen[i] = valid;
        end
        n_checks++;
        if (seen !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL latency_pulse: valid by cycle=%b, required 01000000", seen);
        end
        n_checks++;
        if (last_value !== 16'h9765 || valid_cnt !== 1) begin
            n_fail++;
            $display("FAIL latency_value: value=%h pulses=%0d, required 9765/1", last_value, valid_cnt);
        end
    endtask

    task automatic test_short_hold();
        do_reset();
        hold(an_of(0), seg_of(4'h7), 3);
        hold(4'b1111, 7'b1111111, 10);
        for (int i = 1; i < 4; i++) hold(an_of(i), seg_of(4'h3), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL short_hold: pulses=%0d, required 0", valid_cnt);
        end
        hold(an_of(0), seg_of(4'h6), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'h3336) begin
            n_fail++;
            $display("FAIL short_hold_complete: pulses=%0d value=%h, required 1/3336", valid_cnt, last_value);
        end
    endtask

    task automatic test_bad_code();
        do_reset();
        hold(an_of(0), seg_of(4'h1), 8);
        hold(an_of(1), seg_of(4'h2), 8);
        hold(an_of(2), 7'b1111111, 8);
        hold(an_of(3), seg_of(4'h4), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_err !== 1'b1 || last_value !== 16'h4021) begin
            n_fail++;
            $display("FAIL bad_code: pulses=%0d value=%h err=%b, required 1/4021/1", valid_cnt, last_value, last_err);
        end
        for (int i = 0; i < 4; i++) hold(an_of(i), seg_of(4'h2), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 2 || last_err !== 1'b0 || last_value !== 16'h2222) begin
            n_fail++;
            $display("FAIL err_cleared: pulses=%0d value=%h err=%b, required 2/2222/0", valid_cnt, last_value, last_err);
        end
        hold(an_of(0), 7'b1100000, 8);
        for (int i = 1; i < 4; i++) hold(an_of(i), seg_of(4'h1), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 3 || last_err !== 1'b1 || last_value !== 16'h1110) begin
            n_fail++;
            $display("FAIL code_b: pulses=%0d value=%h err=%b, required 3/1110/1", valid_cnt, last_value, last_err);
        end
    endtask

    task automatic test_multi_low();
        do_reset();
        hold(4'b0011, seg_of(4'h1), 20);
        hold(4'b1111, seg_of(4'h1), 20);
        hold(4'b0000, seg_of(4'h5), 20);
        for (int i = 0; i < 3; i++) hold(an_of(i), seg_of(4'h8), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL multi_low: pulses=%0d, required 0", valid_cnt);
        end
        hold(an_of(3), seg_of(4'hE), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'hE888) begin
            n_fail++;
            $display("FAIL multi_low_complete: pulses=%0d value=%h, required 1/E888", valid_cnt, last_value);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        hold(an_of(0), seg_of(4'h1), 8);
        hold(an_of(1), seg_of(4'h2), 8);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        hold(an_of(2), seg_of(4'h3), 8);
        hold(an_of(3), seg_of(4'h4), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 0 || value !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: pulses=%0d value=%h, required 0/0000", valid_cnt, value);
        end
        hold(an_of(0), seg_of(4'hA), 8);
        hold(an_of(1), seg_of(4'hC), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'h43CA) begin
            n_fail++;
            $display("FAIL mid_reset_complete: pulses=%0d value=%h, required 1/43CA", valid_cnt, last_value);
        end
    endtask

    task automatic test_eight_zero();
        do_reset();
        hold(an_of(0), 7'b0000000, 8);
        hold(an_of(1), 7'b0000001, 8);
        hold(an_of(2), 7'b0000001, 8);
        hold(an_of(3), 7'b0000001, 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'h0008 || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL eight_zero: pulses=%0d value=%h err=%b, required 1/0008/0", valid_cnt, last_value, last_err);
        end
    endtask

    task automatic test_overwrite_hex();
        do_reset();
        hold(an_of(0), seg_of(4'h5), 8);
        hold(an_of(0), seg_of(4'hA), 8);
        hold(an_of(1), seg_of(4'hC), 8);
        hold(an_of(2), seg_of(4'hE), 8);
        hold(an_of(3), seg_of(4'hF), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 1 || last_value !== 16'hFECA || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overwrite_hex: pulses=%0d value=%h err=%b, required 1/FECA/0", valid_cnt, last_value, last_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) hold(an_of(i), seg_of(4'h9), 8);
        for (int i = 0; i < 4; i++) hold(an_of(i), seg_of(4'(i)), 8);
        idle(6);
        n_checks++;
        if (valid_cnt !== 2 || last_value !== 16'h3210) begin
            n_fail++;
            $display("FAIL back_to_back: pulses=%0d value=%h, required 2/3210", valid_cnt, last_value);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        valid_cnt = 0;
        reset     = 1'b0;
        an        = 4'b1111;
        seg       = 7'b1111111;
        test_reset();
        test_basic_frame();
        test_latency();
        test_short_hold();
        test_bad_code();
        test_multi_low();
        test_mid_reset();
        test_eight_zero();
        test_overwrite_hex();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
